// File: rtl/axis_loopback_nf.sv
// axis_loopback_nf
// Data-plane stand-in for OPED bring-up. The egress stream (M_AXIS_*) is fed
// either from a DEPTH-entry first-word-fall-through FIFO filled by the ingress
// stream (S_AXIS_*), or from a built-in packet generator, depending on the
// mode in force.
// Ports:
//   ACLK, ARESETN       clock, asynchronous active-low reset
//   MODE                requested mode: 0 loopback, 1 sink, 2 generate, 3 hold
//   S_AXIS_*            ingress data beat plus per-beat sideband (LEN/SPT/DPT/ERR)
//   M_AXIS_*            egress data beat plus per-beat sideband
//   ACTIVE_MODE         mode currently in force
//   FIFO_LEVEL          occupied FIFO entries
//   PKT_IN_COUNT        ingress TLAST handshakes accepted (wraps)
//   PKT_OUT_COUNT       egress TLAST handshakes completed (wraps)
module axis_loopback_nf #(
  parameter int DATA_W     = 256,
  parameter int DEPTH      = 16,
  parameter int SWAP_PORTS = 1,
  parameter int GEN_BEATS  = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [1:0]               MODE,
  input  logic [DATA_W-1:0]        S_AXIS_DAT_TDATA,
  input  logic                     S_AXIS_DAT_TVALID,
  input  logic [DATA_W/8-1:0]      S_AXIS_DAT_TSTRB,
  input  logic                     S_AXIS_DAT_TLAST,
  output logic                     S_AXIS_DAT_TREADY,
  input  logic [15:0]              S_AXIS_LEN_TDATA,
  input  logic [7:0]               S_AXIS_SPT_TDATA,
  input  logic [7:0]               S_AXIS_DPT_TDATA,
  input  logic                     S_AXIS_ERR_TDATA,
  output logic [DATA_W-1:0]        M_AXIS_DAT_TDATA,
  output logic                     M_AXIS_DAT_TVALID,
  output logic [DATA_W/8-1:0]      M_AXIS_DAT_TSTRB,
  output logic                     M_AXIS_DAT_TLAST,
  input  logic                     M_AXIS_DAT_TREADY,
  output logic [15:0]              M_AXIS_LEN_TDATA,
  output logic [7:0]               M_AXIS_SPT_TDATA,
  output logic [7:0]               M_AXIS_DPT_TDATA,
  output logic                     M_AXIS_ERR_TDATA,
  output logic [1:0]               ACTIVE_MODE,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output logic [31:0]              PKT_IN_COUNT,
  output logic [31:0]              PKT_OUT_COUNT
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LANES     = DATA_W / 32;
  localparam int AW        = $clog2(DEPTH);
  localparam int LVL_W     = AW + 1;
  localparam int ENTRY_W   = DATA_W + STRB_W + 1 + 16 + 8 + 8 + 1;
  localparam int GB_W      = (GEN_BEATS > 1) ? $clog2(GEN_BEATS) : 1;
  localparam int GEN_BYTES = GEN_BEATS * STRB_W;
  localparam logic [15:0] GEN_LEN = GEN_BYTES[15:0];

  typedef enum logic [1:0] {LOOP = 2'd0, SINK = 2'd1, GEN = 2'd2, HOLD = 2'd3} mode_t;

  mode_t                state, next_state;
  logic                 run;
  logic                 in_pkt;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [31:0]          seq;
  logic [GB_W-1:0]      gen_beat;
  logic [31:0]          pkt_in_count, pkt_out_count;

  logic                 full, empty, quiet;
  logic                 s_ready, src_gen, m_valid;
  logic                 s_hs, m_hs, wr_en, rd_en;
  logic [DATA_W-1:0]    h_data, gen_data;
  logic [STRB_W-1:0]    h_strb;
  logic                 h_last, h_err;
  logic [15:0]          h_len;
  logic [7:0]           h_spt, h_dpt;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign quiet = !in_pkt && empty && (gen_beat == '0);

  // Mode state register; run stays low while reset is held so TREADY is 0.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= LOOP;
      run   <= 1'b0;
    end else begin
      state <= next_state;
      run   <= 1'b1;
    end
  end

  // Mode changes only take effect once nothing is in flight.
  always_comb begin
    next_state = state;
    if (quiet) next_state = mode_t'(MODE);
  end

  always_comb begin
    s_ready = 1'b0;
    if (run) begin
      case (state)
        LOOP:      s_ready = !full;
        SINK, GEN: s_ready = 1'b1;
        default:   s_ready = 1'b0;
      endcase
    end
    src_gen = (state == GEN);
    m_valid = src_gen ? run : !empty;
  end

  assign s_hs  = S_AXIS_DAT_TVALID && s_ready;
  assign m_hs  = m_valid && M_AXIS_DAT_TREADY;
  assign wr_en = s_hs && (state == LOOP);
  assign rd_en = m_hs && !src_gen;

  // FIFO storage holds payload only, so it needs no reset.
  always_ff @(posedge ACLK) begin
    if (wr_en)
      mem[wr_ptr] <= {S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TLAST,
                      S_AXIS_LEN_TDATA, S_AXIS_SPT_TDATA, S_AXIS_DPT_TDATA,
                      S_AXIS_ERR_TDATA};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVL_W'(wr_en) - LVL_W'(rd_en);
    end
  end

  // Ingress packet tracking, generator position and packet counters.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      in_pkt        <= 1'b0;
      seq           <= '0;
      gen_beat      <= '0;
      pkt_in_count  <= '0;
      pkt_out_count <= '0;
    end else begin
      if (s_hs) in_pkt <= !S_AXIS_DAT_TLAST;
      if (m_hs && src_gen) begin
        seq      <= seq + 32'(LANES);
        gen_beat <= (gen_beat == GB_W'(GEN_BEATS - 1)) ? '0 : gen_beat + GB_W'(1);
      end
      if (s_hs && S_AXIS_DAT_TLAST) pkt_in_count <= pkt_in_count + 32'd1;
      if (m_hs && M_AXIS_DAT_TLAST) pkt_out_count <= pkt_out_count + 32'd1;
    end
  end

  assign {h_data, h_strb, h_last, h_len, h_spt, h_dpt, h_err} = mem[rd_ptr];

  always_comb begin
    gen_data = '0;
    for (int i = 0; i < LANES; i++) gen_data[i*32 +: 32] = seq + 32'(i);
  end

  // Egress mux; everything reads zero when no beat is offered.
  always_comb begin
    M_AXIS_DAT_TDATA = '0;
    M_AXIS_DAT_TSTRB = '0;
    M_AXIS_DAT_TLAST = 1'b0;
    M_AXIS_LEN_TDATA = '0;
    M_AXIS_SPT_TDATA = '0;
    M_AXIS_DPT_TDATA = '0;
    M_AXIS_ERR_TDATA = 1'b0;
    if (src_gen && run) begin
      M_AXIS_DAT_TDATA = gen_data;
      M_AXIS_DAT_TSTRB = '1;
      M_AXIS_DAT_TLAST = (gen_beat == GB_W'(GEN_BEATS - 1));
      M_AXIS_LEN_TDATA = GEN_LEN;
    end else if (!src_gen && !empty) begin
      M_AXIS_DAT_TDATA = h_data;
      M_AXIS_DAT_TSTRB = h_strb;
      M_AXIS_DAT_TLAST = h_last;
      M_AXIS_LEN_TDATA = h_len;
      M_AXIS_SPT_TDATA = (SWAP_PORTS != 0) ? h_dpt : h_spt;
      M_AXIS_DPT_TDATA = (SWAP_PORTS != 0) ? h_spt : h_dpt;
      M_AXIS_ERR_TDATA = h_err;
    end
  end

  assign S_AXIS_DAT_TREADY = s_ready;
  assign M_AXIS_DAT_TVALID = m_valid;
  assign ACTIVE_MODE       = state;
  assign FIFO_LEVEL        = level;
  assign PKT_IN_COUNT      = pkt_in_count;
  assign PKT_OUT_COUNT     = pkt_out_count;

endmodule

// File: tb/tb_axis_loopback_nf.sv
// Testbench for axis_loopback_nf (DATA_W=256, DEPTH=16, SWAP_PORTS=1, GEN_BEATS=4).
// Inputs change on the falling edge; outputs are sampled between edges.
module tb_axis_loopback_nf;

  localparam int DW = 256;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic [15:0]   len;
    logic [7:0]    spt;
    logic [7:0]    dpt;
    logic          err;
  } beat_t;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [1:0]    MODE;
  logic [DW-1:0] S_AXIS_DAT_TDATA;
  logic          S_AXIS_DAT_TVALID;
  logic [SW-1:0] S_AXIS_DAT_TSTRB;
  logic          S_AXIS_DAT_TLAST;
  logic          S_AXIS_DAT_TREADY;
  logic [15:0]   S_AXIS_LEN_TDATA;
  logic [7:0]    S_AXIS_SPT_TDATA;
  logic [7:0]    S_AXIS_DPT_TDATA;
  logic          S_AXIS_ERR_TDATA;
  logic [DW-1:0] M_AXIS_DAT_TDATA;
  logic          M_AXIS_DAT_TVALID;
  logic [SW-1:0] M_AXIS_DAT_TSTRB;
  logic          M_AXIS_DAT_TLAST;
  logic          M_AXIS_DAT_TREADY;
  logic [15:0]   M_AXIS_LEN_TDATA;
  logic [7:0]    M_AXIS_SPT_TDATA;
  logic [7:0]    M_AXIS_DPT_TDATA;
  logic          M_AXIS_ERR_TDATA;
  logic [1:0]    ACTIVE_MODE;
  logic [4:0]    FIFO_LEVEL;
  logic [31:0]   PKT_IN_COUNT;
  logic [31:0]   PKT_OUT_COUNT;

  axis_loopback_nf #(.DATA_W(DW), .DEPTH(16), .SWAP_PORTS(1), .GEN_BEATS(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .MODE(MODE),
    .S_AXIS_DAT_TDATA(S_AXIS_DAT_TDATA), .S_AXIS_DAT_TVALID(S_AXIS_DAT_TVALID),
    .S_AXIS_DAT_TSTRB(S_AXIS_DAT_TSTRB), .S_AXIS_DAT_TLAST(S_AXIS_DAT_TLAST),
    .S_AXIS_DAT_TREADY(S_AXIS_DAT_TREADY), .S_AXIS_LEN_TDATA(S_AXIS_LEN_TDATA),
    .S_AXIS_SPT_TDATA(S_AXIS_SPT_TDATA), .S_AXIS_DPT_TDATA(S_AXIS_DPT_TDATA),
    .S_AXIS_ERR_TDATA(S_AXIS_ERR_TDATA),
    .M_AXIS_DAT_TDATA(M_AXIS_DAT_TDATA), .M_AXIS_DAT_TVALID(M_AXIS_DAT_TVALID),
    .M_AXIS_DAT_TSTRB(M_AXIS_DAT_TSTRB), .M_AXIS_DAT_TLAST(M_AXIS_DAT_TLAST),
    .M_AXIS_DAT_TREADY(M_AXIS_DAT_TREADY), .M_AXIS_LEN_TDATA(M_AXIS_LEN_TDATA),
    .M_AXIS_SPT_TDATA(M_AXIS_SPT_TDATA), .M_AXIS_DPT_TDATA(M_AXIS_DPT_TDATA),
    .M_AXIS_ERR_TDATA(M_AXIS_ERR_TDATA),
    .ACTIVE_MODE(ACTIVE_MODE), .FIFO_LEVEL(FIFO_LEVEL),
    .PKT_IN_COUNT(PKT_IN_COUNT), .PKT_OUT_COUNT(PKT_OUT_COUNT)
  );

  always #5 ACLK = ~ACLK;

  int    nchk = 0;
  int    nfail = 0;
  int    npop = 0;
  bit    s_hs, m_hs;
  bit    sb_push, sb_check;
  beat_t sb_q[$];

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    b.strb = SW'($urandom);
    b.last = last;
    b.len  = 16'($urandom);
    b.spt  = 8'($urandom);
    b.dpt  = 8'($urandom);
    b.err  = 1'($urandom);
    return b;
  endfunction

  function automatic logic [DW-1:0] gen_exp(input logic [31:0] s);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = s + 32'(i);
    return d;
  endfunction

  task automatic drive(input beat_t b);
    S_AXIS_DAT_TVALID = 1'b1;
    S_AXIS_DAT_TDATA  = b.data;
    S_AXIS_DAT_TSTRB  = b.strb;
    S_AXIS_DAT_TLAST  = b.last;
    S_AXIS_LEN_TDATA  = b.len;
    S_AXIS_SPT_TDATA  = b.spt;
    S_AXIS_DPT_TDATA  = b.dpt;
    S_AXIS_ERR_TDATA  = b.err;
  endtask

  // One clock: sample handshakes just before the rising edge, run the
  // scoreboard, then return on the following falling edge.
  task automatic tick();
    beat_t e, g;
    #2;
    s_hs = S_AXIS_DAT_TVALID && S_AXIS_DAT_TREADY;
    m_hs = M_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY;
    if (m_hs && sb_check) begin
      nchk++;
      if (sb_q.size() == 0) begin
        nfail++;
        $display("FAIL sb_unexpected_beat: got data %h last %b, expected no beat",
                 M_AXIS_DAT_TDATA[63:0], M_AXIS_DAT_TLAST);
      end else begin
        e = sb_q.pop_front();
        g = '{M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TLAST, M_AXIS_LEN_TDATA,
              M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA, M_AXIS_ERR_TDATA};
        npop++;
        if (g !== e) begin
          nfail++;
          $display("FAIL sb_beat: got %h expected %h", g, e);
        end
      end
    end
    if (s_hs && sb_push) begin
      e = '{S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TLAST, S_AXIS_LEN_TDATA,
            S_AXIS_DPT_TDATA, S_AXIS_SPT_TDATA, S_AXIS_ERR_TDATA};
      sb_q.push_back(e);
    end
    @(negedge ACLK);
  endtask

  task automatic run_until_empty(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sb_q.size() == 0 && FIFO_LEVEL == 0 && !M_AXIS_DAT_TVALID) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    S_AXIS_DAT_TVALID = 1'b0;
    M_AXIS_DAT_TREADY = 1'b0;
    MODE = 2'd0;
    sb_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [511:0] outs;
    ARESETN = 1'b0;
    S_AXIS_DAT_TVALID = 1'b1;
    M_AXIS_DAT_TREADY = 1'b1;
    #1;
    outs = {S_AXIS_DAT_TREADY, M_AXIS_DAT_TVALID, M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB,
            M_AXIS_DAT_TLAST, M_AXIS_LEN_TDATA, M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA,
            M_AXIS_ERR_TDATA, ACTIVE_MODE, FIFO_LEVEL, PKT_IN_COUNT, PKT_OUT_COUNT};
    nchk++;
    if (outs !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    S_AXIS_DAT_TVALID = 1'b0;
    tick();
    nchk++;
    if (S_AXIS_DAT_TREADY !== 1'b1 || ACTIVE_MODE !== 2'd0) begin
      nfail++;
      $display("FAIL reset_release: got tready %b mode %0d expected 1 0",
               S_AXIS_DAT_TREADY, ACTIVE_MODE);
    end
  endtask

  task automatic test_loop_basic();
    beat_t b;
    bit ok;
    int n0;
    do_reset();
    sb_push = 1; sb_check = 1;
    M_AXIS_DAT_TREADY = 1'b1;
    b = rand_beat(1'b0);
    b.strb = '1; b.len = 16'd96; b.spt = 8'h12; b.dpt = 8'h34; b.err = 1'b0;
    n0 = npop;
    for (int k = 0; k < 3; k++) begin
      b.last = (k == 2);
      drive(b);
      if (k == 0) begin
        nchk++;
        if (M_AXIS_DAT_TVALID !== 1'b0) begin
          nfail++;
          $display("FAIL loop_empty_valid: got %b expected 0", M_AXIS_DAT_TVALID);
        end
      end
      tick();
      nchk++;
      if (!s_hs) begin
        nfail++;
        $display("FAIL loop_accept: got tready 0 expected 1 on beat %0d", k);
      end
      if (k == 0) begin
        nchk++;
        if (M_AXIS_DAT_TVALID !== 1'b1 || FIFO_LEVEL !== 5'd1) begin
          nfail++;
          $display("FAIL loop_first_latency: got valid %b level %0d expected 1 1",
                   M_AXIS_DAT_TVALID, FIFO_LEVEL);
        end
      end
    end
    S_AXIS_DAT_TVALID = 1'b0;
    run_until_empty(20, ok);
    nchk++;
    if (!ok || npop - n0 != 3) begin
      nfail++;
      $display("FAIL loop_drain: got ok %b beats %0d expected 1 3", ok, npop - n0);
    end
    nchk++;
    if (PKT_IN_COUNT !== 32'd1 || PKT_OUT_COUNT !== 32'd1) begin
      nfail++;
      $display("FAIL loop_counts: got %0d %0d expected 1 1", PKT_IN_COUNT, PKT_OUT_COUNT);
    end
  endtask

  task automatic test_backpressure();
    beat_t bp[20];
    int k, n0;
    bit ok;
    do_reset();
    sb_push = 1; sb_check = 1;
    for (int i = 0; i < 20; i++) bp[i] = rand_beat(i % 5 == 4);
    n0 = npop;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (k < 20) drive(bp[k]); else S_AXIS_DAT_TVALID = 1'b0;
      tick();
      if (s_hs) k++;
    end
    nchk++;
    if (k != 16 || FIFO_LEVEL !== 5'd16 || S_AXIS_DAT_TREADY !== 1'b0) begin
      nfail++;
      $display("FAIL bp_full: got accepted %0d level %0d tready %b expected 16 16 0",
               k, FIFO_LEVEL, S_AXIS_DAT_TREADY);
    end
    M_AXIS_DAT_TREADY = 1'b1;
    for (int c = 0; c < 40 && k < 20; c++) begin
      drive(bp[k]);
      tick();
      if (s_hs) k++;
    end
    S_AXIS_DAT_TVALID = 1'b0;
    run_until_empty(40, ok);
    nchk++;
    if (!ok || k != 20 || npop - n0 != 20) begin
      nfail++;
      $display("FAIL bp_drain: got ok %b accepted %0d emitted %0d expected 1 20 20",
               ok, k, npop - n0);
    end
    nchk++;
    if (PKT_IN_COUNT !== 32'd4 || PKT_OUT_COUNT !== 32'd4) begin
      nfail++;
      $display("FAIL bp_counts: got %0d %0d expected 4 4", PKT_IN_COUNT, PKT_OUT_COUNT);
    end
  endtask

  task automatic test_mode_change();
    int k;
    bit seen;
    do_reset();
    sb_push = 1; sb_check = 1;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      drive(rand_beat(k == 3));
      tick();
      if (s_hs) k++;
      if (k == 2) MODE = 2'd1;
    end
    S_AXIS_DAT_TVALID = 1'b0;
    sb_push = 0;
    tick(); tick();
    nchk++;
    if (k != 4 || ACTIVE_MODE !== 2'd0 || FIFO_LEVEL !== 5'd4) begin
      nfail++;
      $display("FAIL mode_hold_old: got accepted %0d mode %0d level %0d expected 4 0 4",
               k, ACTIVE_MODE, FIFO_LEVEL);
    end
    M_AXIS_DAT_TREADY = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (ACTIVE_MODE == 2'd1) seen = 1; else tick();
    end
    nchk++;
    if (!seen || FIFO_LEVEL !== 5'd0 || sb_q.size() != 0) begin
      nfail++;
      $display("FAIL mode_switch: got switched %b level %0d pending %0d expected 1 0 0",
               seen, FIFO_LEVEL, sb_q.size());
    end
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      drive(rand_beat(k % 2 == 1));
      tick();
      if (s_hs) k++;
    end
    S_AXIS_DAT_TVALID = 1'b0;
    repeat (3) tick();
    nchk++;
    if (k != 4 || M_AXIS_DAT_TVALID !== 1'b0 || FIFO_LEVEL !== 5'd0) begin
      nfail++;
      $display("FAIL sink_discard: got accepted %0d valid %b level %0d expected 4 0 0",
               k, M_AXIS_DAT_TVALID, FIFO_LEVEL);
    end
    nchk++;
    if (PKT_IN_COUNT !== 32'd3 || PKT_OUT_COUNT !== 32'd1) begin
      nfail++;
      $display("FAIL sink_counts: got %0d %0d expected 3 1", PKT_IN_COUNT, PKT_OUT_COUNT);
    end
  endtask

  task automatic test_gen();
    logic [31:0] seq;
    int beat, nhs;
    bit seen;
    logic [DW+SW+43:0] got, exp;
    do_reset();
    sb_push = 0; sb_check = 0;
    MODE = 2'd2;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (ACTIVE_MODE == 2'd2) seen = 1; else tick();
    end
    nchk++;
    if (!seen) begin
      nfail++;
      $display("FAIL gen_enter: got mode %0d expected 2", ACTIVE_MODE);
    end
    seq = 32'd0; beat = 0; nhs = 0;
    for (int c = 0; c < 24; c++) begin
      M_AXIS_DAT_TREADY = c[0];
      got = {M_AXIS_DAT_TVALID, M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB, M_AXIS_DAT_TLAST,
             M_AXIS_LEN_TDATA, M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA, M_AXIS_ERR_TDATA};
      exp = {1'b1, gen_exp(seq), {SW{1'b1}}, (beat == 3), 16'd128, 8'd0, 8'd0, 1'b0};
      nchk++;
      if (got !== exp) begin
        nfail++;
        $display("FAIL gen_beat%0d: got %h expected %h", c, got, exp);
      end
      tick();
      if (m_hs) begin
        nhs++;
        seq = seq + 32'd8;
        beat = (beat + 1) % 4;
      end
    end
    nchk++;
    if (nhs != 12 || PKT_OUT_COUNT !== 32'd3) begin
      nfail++;
      $display("FAIL gen_counts: got beats %0d pkts %0d expected 12 3", nhs, PKT_OUT_COUNT);
    end
    M_AXIS_DAT_TREADY = 1'b0;
    MODE = 2'd0;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (ACTIVE_MODE == 2'd0) seen = 1; else tick();
    end
    nchk++;
    if (!seen) begin
      nfail++;
      $display("FAIL gen_exit: got mode %0d expected 0", ACTIVE_MODE);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] outs;
    int k, nvalid;
    do_reset();
    sb_push = 1; sb_check = 1;
    k = 0;
    for (int c = 0; c < 10 && k < 5; c++) begin
      drive(rand_beat(1'b0));
      tick();
      if (s_hs) k++;
    end
    nchk++;
    if (FIFO_LEVEL !== 5'd5) begin
      nfail++;
      $display("FAIL rstmid_level: got %0d expected 5", FIFO_LEVEL);
    end
    ARESETN = 1'b0;
    #1;
    outs = {S_AXIS_DAT_TREADY, M_AXIS_DAT_TVALID, M_AXIS_DAT_TDATA, M_AXIS_DAT_TSTRB,
            M_AXIS_DAT_TLAST, M_AXIS_LEN_TDATA, M_AXIS_SPT_TDATA, M_AXIS_DPT_TDATA,
            M_AXIS_ERR_TDATA, ACTIVE_MODE, FIFO_LEVEL, PKT_IN_COUNT, PKT_OUT_COUNT};
    nchk++;
    if (outs !== '0) begin
      nfail++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    sb_q.delete();
    @(negedge ACLK);
    ARESETN = 1'b1;
    S_AXIS_DAT_TVALID = 1'b0;
    M_AXIS_DAT_TREADY = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      if (M_AXIS_DAT_TVALID) nvalid++;
      tick();
    end
    nchk++;
    if (nvalid != 0 || ACTIVE_MODE !== 2'd0 || FIFO_LEVEL !== 5'd0 ||
        PKT_IN_COUNT !== 32'd0 || PKT_OUT_COUNT !== 32'd0) begin
      nfail++;
      $display("FAIL rstmid_after: got stale %0d mode %0d level %0d in %0d out %0d expected all 0",
               nvalid, ACTIVE_MODE, FIFO_LEVEL, PKT_IN_COUNT, PKT_OUT_COUNT);
    end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    sb_push = 1; sb_check = 1;
    M_AXIS_DAT_TREADY = 1'b1;
    force dut.pkt_out_count = 32'hFFFF_FFFF;
    @(negedge ACLK);
    release dut.pkt_out_count;
    nchk++;
    if (PKT_OUT_COUNT !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL wrap_preload: got %h expected ffffffff", PKT_OUT_COUNT);
    end
    drive(rand_beat(1'b1));
    tick();
    S_AXIS_DAT_TVALID = 1'b0;
    run_until_empty(10, ok);
    nchk++;
    if (!ok || PKT_OUT_COUNT !== 32'd0 || PKT_IN_COUNT !== 32'd1) begin
      nfail++;
      $display("FAIL wrap_count: got ok %b out %h in %0d expected 1 00000000 1",
               ok, PKT_OUT_COUNT, PKT_IN_COUNT);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    MODE = 2'd0;
    S_AXIS_DAT_TVALID = 1'b0;
    S_AXIS_DAT_TDATA = '0;
    S_AXIS_DAT_TSTRB = '0;
    S_AXIS_DAT_TLAST = 1'b0;
    S_AXIS_LEN_TDATA = '0;
    S_AXIS_SPT_TDATA = '0;
    S_AXIS_DPT_TDATA = '0;
    S_AXIS_ERR_TDATA = 1'b0;
    M_AXIS_DAT_TREADY = 1'b0;
    sb_push = 0; sb_check = 0;
    @(negedge ACLK);
    test_reset();
    test_loop_basic();
    test_backpressure();
    test_mode_change();
    test_gen();
    test_reset_mid();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
